// File: rtl/shake_pad_unit_pkg.sv
// Shared constants, state encoding and helpers for the SHAKE pad and absorb stages.
package shake_pad_unit_pkg;

  localparam int unsigned RATE_BITS_SHAKE128 = 1344;
  localparam int unsigned RATE_BITS_SHAKE256 = 1088;
  localparam int unsigned WORD_W             = 64;
  localparam int unsigned BYTE_W             = 8;
  localparam int unsigned NBYTES             = WORD_W / BYTE_W;

  localparam logic [7:0] DS_SHAKE      = 8'h1F;
  localparam logic [7:0] DS_SHA3       = 8'h06;
  localparam logic [7:0] PAD_LAST_BYTE = 8'h80;

  typedef enum logic [1:0] {
    ST_PASS = 2'd0,
    ST_PAD0 = 2'd1,
    ST_FILL = 2'd2
  } pad_state_e;

  // Byte counts above a full word are treated as a full word.
  function automatic logic [3:0] clamp_bytes(input logic [3:0] n);
    return (n > 4'd8) ? 4'd8 : n;
  endfunction

endpackage

// File: rtl/shake_pad_byte_mask.sv
// Keeps the first n bytes, inserts the domain byte at n, zeroes the rest,
// and ORs 0x80 into byte 7 when the word closes a rate block.
module shake_pad_byte_mask
  import shake_pad_unit_pkg::*;
#(
  parameter logic [7:0] DS_BYTE = DS_SHAKE
) (
  input  logic [63:0] data_i,
  input  logic [2:0]  nbytes_i,
  input  logic        block_end_i,
  output logic [63:0] data_o
);

  always_comb begin
    data_o = '0;
    for (int i = 0; i < 8; i++) begin
      if (3'(i) < nbytes_i) begin
        data_o[i*8 +: 8] = data_i[i*8 +: 8];
      end else if (3'(i) == nbytes_i) begin
        data_o[i*8 +: 8] = DS_BYTE;
      end
    end
    if (block_end_i) begin
      data_o[63:56] = data_o[63:56] | PAD_LAST_BYTE;
    end
  end

endmodule

// File: rtl/shake_pad_unit.sv
// SHAKE/SHA3 multi-rate padder feeding the absorb stage one 64-bit rate word per handshake.
// Optional SHAKE_PAD_BLOCK_COUNT_EN adds a free-running blk_count of emitted rate blocks.
module shake_pad_unit
  import shake_pad_unit_pkg::*;
#(
  parameter int unsigned RATE_BITS = 1088,
  parameter logic [7:0]  DS_BYTE   = DS_SHAKE
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        msg_valid,
  input  logic [63:0] msg_data,
  input  logic        msg_last,
  input  logic [3:0]  msg_bytes,
  output logic        msg_ready,
  output logic        out_valid,
  output logic [63:0] out_data,
  input  logic        out_ready,
  output logic        msg_done
`ifdef SHAKE_PAD_BLOCK_COUNT_EN
  ,
  output logic [31:0] blk_count
`endif
);

  localparam int unsigned WORDS = RATE_BITS / 64;
  localparam int unsigned CNT_W = (WORDS > 1) ? $clog2(WORDS) : 1;

  pad_state_e       state_q, state_d;
  logic [CNT_W-1:0] wcnt_q, wcnt_d;
  logic             out_valid_q, out_valid_d;
  logic [63:0]      out_data_q, out_data_d;
  logic             fin_q, fin_d;
  logic             bend_q, bend_d;

  logic        load;
  logic        accept;
  logic        block_end;
  logic [3:0]  nb;
  logic [63:0] mask_in;
  logic [2:0]  mask_n;
  logic [63:0] mask_data;

  assign block_end = (wcnt_q == CNT_W'(WORDS - 1));
  assign load      = !out_valid_q || out_ready;
  assign msg_ready = (state_q == ST_PASS) && load;
  assign accept    = msg_valid && msg_ready;
  assign nb        = clamp_bytes(msg_bytes);

  // PAD0 reuses the mask with an empty payload so byte 0 becomes the domain byte.
  assign mask_in = (state_q == ST_PAD0) ? 64'h0 : msg_data;
  assign mask_n  = (state_q == ST_PAD0) ? 3'd0 : nb[2:0];

  shake_pad_byte_mask #(
    .DS_BYTE (DS_BYTE)
  ) u_mask (
    .data_i      (mask_in),
    .nbytes_i    (mask_n),
    .block_end_i (block_end),
    .data_o      (mask_data)
  );

  always_comb begin
    state_d     = state_q;
    wcnt_d      = wcnt_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    fin_d       = fin_q;
    bend_d      = bend_q;
    if (load) begin
      out_valid_d = 1'b0;
      fin_d       = 1'b0;
      bend_d      = 1'b0;
      unique case (state_q)
        ST_PASS: begin
          if (accept) begin
            out_valid_d = 1'b1;
            bend_d      = block_end;
            out_data_d  = msg_data;
            if (msg_last) begin
              if (nb == 4'd8) begin
                state_d = ST_PAD0;
              end else begin
                out_data_d = mask_data;
                if (block_end) fin_d = 1'b1;
                else           state_d = ST_FILL;
              end
            end
          end
        end
        ST_PAD0: begin
          out_valid_d = 1'b1;
          bend_d      = block_end;
          out_data_d  = mask_data;
          if (block_end) begin
            fin_d   = 1'b1;
            state_d = ST_PASS;
          end else begin
            state_d = ST_FILL;
          end
        end
        ST_FILL: begin
          out_valid_d = 1'b1;
          bend_d      = block_end;
          out_data_d  = block_end ? {PAD_LAST_BYTE, 56'h0} : 64'h0;
          if (block_end) begin
            fin_d   = 1'b1;
            state_d = ST_PASS;
          end
        end
        default: state_d = ST_PASS;
      endcase
      // Wrapping at the block end also returns the count to 0 on completion.
      if (out_valid_d) begin
        wcnt_d = block_end ? '0 : wcnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_PASS;
      wcnt_q      <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      fin_q       <= 1'b0;
      bend_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      wcnt_q      <= wcnt_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      fin_q       <= fin_d;
      bend_q      <= bend_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign msg_done  = out_valid_q && out_ready && fin_q;

`ifdef SHAKE_PAD_BLOCK_COUNT_EN
  logic [31:0] blk_cnt_q, blk_cnt_d;

  assign blk_cnt_d = (out_valid_q && out_ready && bend_q) ? blk_cnt_q + 32'd1 : blk_cnt_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) blk_cnt_q <= '0;
    else       blk_cnt_q <= blk_cnt_d;
  end

  assign blk_count = blk_cnt_q;
`endif

endmodule

// File: tb/tb_shake_pad_unit.sv
// Scoreboard bench for shake_pad_unit at RATE_BITS=1088 (17 words per block).
module tb_shake_pad_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        msg_valid = 1'b0;
  logic [63:0] msg_data = '0;
  logic        msg_last = 1'b0;
  logic [3:0]  msg_bytes = '0;
  logic        msg_ready;
  logic        out_valid;
  logic [63:0] out_data;
  logic        out_ready = 1'b1;
  logic        msg_done;
`ifdef SHAKE_PAD_BLOCK_COUNT_EN
  logic [31:0] blk_count;
`endif

  shake_pad_unit #(
    .RATE_BITS (1088),
    .DS_BYTE   (8'h1F)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .msg_valid (msg_valid),
    .msg_data  (msg_data),
    .msg_last  (msg_last),
    .msg_bytes (msg_bytes),
    .msg_ready (msg_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready),
    .msg_done  (msg_done)
`ifdef SHAKE_PAD_BLOCK_COUNT_EN
    ,
    .blk_count (blk_count)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [63:0] d;
    logic        done;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   errors = 0;
  int   checks = 0;
  int   pops   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h want %h", name, act, req);
    end
  endtask

  // Monitor: every word that will handshake at the next rising edge is scored.
  always @(negedge clk) begin
    if (!reset && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_word: got %h want none", out_data);
      end else begin
        mon_e = exp_q.pop_front();
        chk("out_data", out_data, mon_e.d);
        chk("msg_done", 64'(msg_done), 64'(mon_e.done));
        pops++;
      end
    end
  end

  task automatic push(input logic [63:0] d, input logic done);
    exp_q.push_back({d, done});
  endtask

  // Zero words from index 'from' up to 15, then the closing 0x80 word.
  task automatic push_fill(input int from);
    for (int i = from; i < 16; i++) push(64'h0, 1'b0);
    push(64'h8000_0000_0000_0000, 1'b1);
  endtask

  task automatic send(input logic [63:0] d, input logic last, input logic [3:0] nbytes);
    bit ok = 0;
    msg_data  = d;
    msg_last  = last;
    msg_bytes = nbytes;
    msg_valid = 1'b1;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (msg_ready) begin
        ok = 1;
        break;
      end
    end
    @(posedge clk);
    #1;
    msg_valid = 1'b0;
    msg_last  = 1'b0;
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: got msg_ready=0 want 1");
    end
  endtask

  task automatic drain(input string name);
    bit ok = 0;
    for (int k = 0; k < 400; k++) begin
      @(posedge clk);
      if (exp_q.size() == 0) begin
        ok = 1;
        break;
      end
    end
    #1;
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s_drain: got %0d words pending want 0", name, exp_q.size());
    end
  endtask

  task automatic send_abc();
    push(64'h0000_0000_1F63_6261, 1'b0);
    push_fill(1);
    send(64'hFFFF_FFFF_FF63_6261, 1'b1, 4'd3);
  endtask

  task automatic send_17_words_n7();
    for (int i = 0; i < 16; i++) begin
      push(64'h0101_0101_0101_0101 * 64'(i + 1), 1'b0);
      send(64'h0101_0101_0101_0101 * 64'(i + 1), 1'b0, 4'd8);
    end
    push(64'h9F11_2233_4455_6677, 1'b1);
    send(64'h0011_2233_4455_6677, 1'b1, 4'd7);
  endtask

  logic [63:0] held;
  int          base;

  initial begin
    repeat (2) @(negedge clk);
    chk("reset_out_valid", 64'(out_valid), 64'h0);
    chk("reset_out_data", out_data, 64'h0);
    chk("reset_msg_done", 64'(msg_done), 64'h0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    chk("post_reset_msg_ready", 64'(msg_ready), 64'h1);

    // 1: empty message
    push(64'h0000_0000_0000_001F, 1'b0);
    push_fill(1);
    send(64'hDEAD_BEEF_DEAD_BEEF, 1'b1, 4'd0);
    drain("empty");

    // 2: "abc"
    send_abc();
    drain("abc");

    // 3: 16 full words + 7-byte tail closing the block
    send_17_words_n7();
    drain("n7_block_end");

    // 4: 17 full words, padding spills into a second block
    for (int i = 0; i < 17; i++) begin
      push(64'hA5A5_0000_0000_0000 + 64'(i), 1'b0);
      send(64'hA5A5_0000_0000_0000 + 64'(i), (i == 16), (i == 16) ? 4'd8 : 4'd8);
    end
    push(64'h0000_0000_0000_001F, 1'b0);
    push_fill(1);
    drain("full_block");

    // 5: scenario 3 again with a stall while words are streaming
    fork
      send_17_words_n7();
      begin
        repeat (5) @(posedge clk);
        #1;
        out_ready = 1'b0;
        held = out_data;
        repeat (5) begin
          @(negedge clk);
          chk("stall_out_valid", 64'(out_valid), 64'h1);
          chk("stall_out_data", out_data, held);
          chk("stall_msg_ready", 64'(msg_ready), 64'h0);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
    join
    drain("stall");

`ifdef SHAKE_PAD_BLOCK_COUNT_EN
    chk("blk_count", 64'(blk_count), 64'd6);
`endif

    // 6: reset while FILL holds word 7 (wcnt=8)
    base = pops;
    push(64'h0000_0000_0000_001F, 1'b0);
    push_fill(1);
    send(64'h0, 1'b1, 4'd0);
    for (int k = 0; k < 100; k++) begin
      @(posedge clk);
      if (pops >= base + 7) break;
    end
    #1;
    reset = 1'b1;
    #1;
    chk("midreset_out_valid", 64'(out_valid), 64'h0);
    chk("midreset_out_data", out_data, 64'h0);
    chk("midreset_pops", 64'(pops - base), 64'd7);
    exp_q.delete();
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    chk("midreset_msg_ready", 64'(msg_ready), 64'h1);
    send_abc();
    drain("abc_after_reset");

`ifdef SHAKE_PAD_BLOCK_COUNT_EN
    chk("blk_count_after_reset", 64'(blk_count), 64'd1);
`endif

    repeat (3) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
